// File: rtl/mem_wb_pipe_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe_stage_if
// Description : Bundle of the MEM-side and WB-side handshake and payload
//               signals around the MEM/WB pipeline register.
//                 IN_VALID / IN_READY       MEM -> stage handshake
//                 MEM_DATA, ALU_VAL         MEM-stage payload (DATA_W)
//                 REG_DESTINATION           destination index (REG_W)
//                 ALU_CONTROL               writeback control (CTRL_W)
//                 OUT_VALID / OUT_READY     stage -> WB handshake
//                 *_OUT                     registered payload towards WB
//               modport master : environment (MEM producer + WB consumer)
//               modport slave  : the pipeline stage itself
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 2
);
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] MEM_DATA;
  logic [DATA_W-1:0] ALU_VAL;
  logic [REG_W-1:0]  REG_DESTINATION;
  logic [CTRL_W-1:0] ALU_CONTROL;

  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] MEM_DATA_OUT;
  logic [DATA_W-1:0] ALU_VAL_OUT;
  logic [REG_W-1:0]  REG_DESTINATION_OUT;
  logic [CTRL_W-1:0] ALU_CONTROL_OUT;

  modport master (
    output IN_VALID, MEM_DATA, ALU_VAL, REG_DESTINATION, ALU_CONTROL, OUT_READY,
    input  IN_READY, OUT_VALID, MEM_DATA_OUT, ALU_VAL_OUT, REG_DESTINATION_OUT,
           ALU_CONTROL_OUT
  );

  modport slave (
    input  IN_VALID, MEM_DATA, ALU_VAL, REG_DESTINATION, ALU_CONTROL, OUT_READY,
    output IN_READY, OUT_VALID, MEM_DATA_OUT, ALU_VAL_OUT, REG_DESTINATION_OUT,
           ALU_CONTROL_OUT
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe_stage
// Description : MEM/WB pipeline register with valid/ready flow control, a
//               2-entry (main + skid) buffer and a synchronous flush.
//               IN_READY is decoded purely from the occupancy state, so a
//               WB-side stall never reaches back into MEM combinationally.
// Ports       : CLK        clock, rising edge
//               RESET_N    asynchronous active-low reset
//               FLUSH      synchronous squash of every held entry
//               bus        mem_wb_pipe_stage_if.slave (handshakes + payload)
//               STALL_CNT  saturating count of OUT_VALID & !OUT_READY cycles
//               FLUSH_CNT  saturating count of flushes that dropped an entry
// Options     : MEM_WB_STATS_EN - when defined, adds STAT_W parameter and the
//               STALL_CNT / FLUSH_CNT counters and ports.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 2
`ifdef MEM_WB_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  wire                CLK,
  input  wire                RESET_N,
  input  wire                FLUSH,
  mem_wb_pipe_stage_if.slave bus
`ifdef MEM_WB_STATS_EN
  ,
  output logic [STAT_W-1:0]  STALL_CNT,
  output logic [STAT_W-1:0]  FLUSH_CNT
`endif
);

  // Payload packed as {mem_data, alu_val, reg_dest, alu_ctrl}.
  localparam int C_PAY_W = 2 * DATA_W + REG_W + CTRL_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [C_PAY_W-1:0] r_main;
  logic [C_PAY_W-1:0] r_skid;
  logic [C_PAY_W-1:0] w_in_pay;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

  // --------------------------------------------------------------------------
  // Handshake decode: both flags depend on the state register only.
  // --------------------------------------------------------------------------
  assign w_in_ready  = (r_state != S_FULL);
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = bus.IN_VALID & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.OUT_READY;

  assign w_in_pay = {bus.MEM_DATA, bus.ALU_VAL, bus.REG_DESTINATION, bus.ALU_CONTROL};

  // --------------------------------------------------------------------------
  // Occupancy FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy FSM: next state and register load enables
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;

    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt  = S_ONE;
          w_ld_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          // Pass-through: the new payload replaces the one just consumed.
          w_ld_main_in = 1'b1;
        end else if (w_in_fire) begin
          // WB stalled while MEM kept sending: park the new payload.
          w_state_nxt = S_FULL;
          w_ld_skid   = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // No input is accepted here; draining promotes the skid entry.
        if (w_out_fire) begin
          w_state_nxt    = S_ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase

    // Flush wins over everything. Loads are suppressed so the *_OUT values
    // stay exactly as they were, while OUT_VALID drops.
    if (FLUSH) begin
      w_state_nxt    = S_EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Payload storage
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= w_in_pay;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_in_pay;
      end
    end
  end

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_VALID = w_out_valid;
  assign {bus.MEM_DATA_OUT, bus.ALU_VAL_OUT, bus.REG_DESTINATION_OUT,
          bus.ALU_CONTROL_OUT} = r_main;

`ifdef MEM_WB_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics: saturating counters, cleared only by reset.
  // --------------------------------------------------------------------------
  logic [STAT_W-1:0] r_stall_cnt;
  logic [STAT_W-1:0] r_flush_cnt;
  logic              w_stall;
  logic              w_flush_hit;

  assign w_stall     = w_out_valid & ~bus.OUT_READY;
  assign w_flush_hit = FLUSH & w_out_valid;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_hit && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign STALL_CNT = r_stall_cnt;
  assign FLUSH_CNT = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_pipe_stage
// Description : Self-checking bench for mem_wb_pipe_stage (DATA_W=64,
//               REG_W=6). Vector table, hand sequences for flush / async
//               reset / width, and random traffic against a queue model.
//               Counter checks are included when MEM_WB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe_stage;

  localparam int DW = 64;
  localparam int RW = 6;
  localparam int CW = 2;

  logic CLK;
  logic RESET_N;
  logic FLUSH;

  mem_wb_pipe_stage_if #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW)) bus ();

`ifdef MEM_WB_STATS_EN
  logic [3:0] STALL_CNT;
  logic [3:0] FLUSH_CNT;
`endif

  mem_wb_pipe_stage #(
    .DATA_W(DW),
    .REG_W (RW),
    .CTRL_W(CW)
`ifdef MEM_WB_STATS_EN
    ,
    .STAT_W(4)
`endif
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .FLUSH  (FLUSH),
    .bus    (bus)
`ifdef MEM_WB_STATS_EN
    ,
    .STALL_CNT(STALL_CNT),
    .FLUSH_CNT(FLUSH_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [DW-1:0] mem;
    logic [DW-1:0] alu;
    logic [RW-1:0] dest;
    logic [CW-1:0] ctrl;
  } pay_t;

  typedef struct {
    logic          fl;
    logic          iv;
    logic          rd;
    logic [DW-1:0] alu;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_alu;
  } vec_t;

  vec_t vecs[$];
  pay_t model_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  // Table payloads are derived from the ALU value so one number fully
  // describes a record.
  function automatic pay_t pay_of(input logic [DW-1:0] a);
    pay_t p;
    p.mem  = ~a;
    p.alu  = a;
    p.dest = a[5:0];
    p.ctrl = a[7:6];
    return p;
  endfunction

  function automatic vec_t mk(input logic fl, input logic iv, input logic rd,
                              input logic [DW-1:0] a, input logic eir, input logic eov,
                              input logic [DW-1:0] ea);
    vec_t v;
    v.fl = fl; v.iv = iv; v.rd = rd; v.alu = a;
    v.e_ir = eir; v.e_ov = eov; v.e_alu = ea;
    return v;
  endfunction

  task automatic drive(input logic fl, input logic iv, input logic rd, input pay_t p);
    FLUSH               = fl;
    bus.IN_VALID        = iv;
    bus.OUT_READY       = rd;
    bus.MEM_DATA        = p.mem;
    bus.ALU_VAL         = p.alu;
    bus.REG_DESTINATION = p.dest;
    bus.ALU_CONTROL     = p.ctrl;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_pay(input string name, input pay_t e);
    chk({name, " mem_out"},  bus.MEM_DATA_OUT,        e.mem);
    chk({name, " alu_out"},  bus.ALU_VAL_OUT,         e.alu);
    chk({name, " dest_out"}, {58'd0, bus.REG_DESTINATION_OUT}, {58'd0, e.dest});
    chk({name, " ctrl_out"}, {62'd0, bus.ALU_CONTROL_OUT},     {62'd0, e.ctrl});
  endtask

  task automatic chk_hs(input string name, input logic eir, input logic eov);
    chk({name, " in_ready"},  {63'd0, bus.IN_READY},  {63'd0, eir});
    chk({name, " out_valid"}, {63'd0, bus.OUT_VALID}, {63'd0, eov});
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0);
    RESET_N = 1'b0;
    cyc();
    cyc();
    chk_hs("reset", 1'b1, 1'b0);
    chk_pay("reset", '0);
    RESET_N = 1'b1;
  endtask

  initial begin
    pay_t p;
    pay_t wide;
    logic fl, iv, rd, eir, eov;

    RESET_N = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    #2;
    do_reset();

    // ---------------- vector table ------------------------------------------
    // Streaming 1..4 with WB always ready.
    vecs.push_back(mk(0, 1, 1, 64'd1, 1, 1, 64'd1));
    vecs.push_back(mk(0, 1, 1, 64'd2, 1, 1, 64'd2));
    vecs.push_back(mk(0, 1, 1, 64'd3, 1, 1, 64'd3));
    vecs.push_back(mk(0, 1, 1, 64'd4, 1, 1, 64'd4));
    vecs.push_back(mk(0, 0, 1, 64'd0, 1, 0, 64'd4));
    // Stall fills the skid; a third offer is refused; drain in order.
    vecs.push_back(mk(0, 1, 0, 64'hAAAA, 1, 1, 64'hAAAA));
    vecs.push_back(mk(0, 1, 0, 64'hBBBB, 0, 1, 64'hAAAA));
    vecs.push_back(mk(0, 1, 0, 64'hCCCC, 0, 1, 64'hAAAA));
    vecs.push_back(mk(0, 0, 1, 64'd0,    1, 1, 64'hBBBB));
    vecs.push_back(mk(0, 0, 1, 64'd0,    1, 0, 64'hBBBB));
    // Flush in FULL with a new offer: everything dropped, outputs frozen.
    vecs.push_back(mk(0, 1, 0, 64'h11, 1, 1, 64'h11));
    vecs.push_back(mk(0, 1, 0, 64'h22, 0, 1, 64'h11));
    vecs.push_back(mk(1, 1, 1, 64'h33, 1, 0, 64'h11));
    vecs.push_back(mk(0, 0, 1, 64'd0,  1, 0, 64'h11));
    vecs.push_back(mk(0, 1, 1, 64'h55, 1, 1, 64'h55));
    vecs.push_back(mk(0, 0, 1, 64'd0,  1, 0, 64'h55));

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].fl, vecs[k].iv, vecs[k].rd, pay_of(vecs[k].alu));
      cyc();
      chk_hs($sformatf("vec%0d", k), vecs[k].e_ir, vecs[k].e_ov);
      chk_pay($sformatf("vec%0d", k), pay_of(vecs[k].e_alu));
    end

    // ---------------- async reset mid-cycle while holding one entry ---------
    drive(1'b0, 1'b1, 1'b0, pay_of(64'h7777));
    cyc();
    chk_hs("areset_pre", 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, '0);
    #3;
    RESET_N = 1'b0;
    #1;
    chk_hs("areset_now", 1'b1, 1'b0);
    chk_pay("areset_now", '0);
    cyc();
    RESET_N = 1'b1;
    drive(1'b0, 1'b1, 1'b1, pay_of(64'h9999));
    cyc();
    chk_hs("first_accept", 1'b1, 1'b1);
    chk_pay("first_accept", pay_of(64'h9999));

    // ---------------- full-width payload -------------------------------------
    wide.mem  = 64'hDEAD_BEEF_0123_4567;
    wide.alu  = 64'h0123_4567_89AB_CDEF;
    wide.dest = 6'h3F;
    wide.ctrl = 2'b10;
    drive(1'b0, 1'b1, 1'b1, wide);
    cyc();
    chk_pay("width", wide);
    drive(1'b0, 1'b0, 1'b1, '0);
    cyc();
    chk_hs("width_drain", 1'b1, 1'b0);

    // ---------------- random traffic vs queue model -------------------------
    do_reset();
    model_q.delete();
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 15) == 0);
      iv = ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 2) != 0);
      p.mem  = {$urandom, $urandom};
      p.alu  = {$urandom, $urandom};
      p.dest = 6'($urandom);
      p.ctrl = 2'($urandom);
      drive(fl, iv, rd, p);
      eir = (model_q.size() < 2);
      eov = (model_q.size() > 0);
      cyc();
      if (fl) begin
        model_q.delete();
      end else begin
        if (eov && rd) void'(model_q.pop_front());
        if (iv && eir) model_q.push_back(p);
      end
      chk_hs($sformatf("rnd%0d", i), model_q.size() < 2, model_q.size() > 0);
      if (model_q.size() > 0) chk_pay($sformatf("rnd%0d", i), model_q[0]);
    end

`ifdef MEM_WB_STATS_EN
    // ---------------- statistics counters -----------------------------------
    do_reset();
    chk("stall_cnt_rst", {60'd0, STALL_CNT}, 64'd0);
    chk("flush_cnt_rst", {60'd0, FLUSH_CNT}, 64'd0);
    drive(1'b0, 1'b1, 1'b0, pay_of(64'h42));
    cyc();
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int n = 0; n < 5; n++) cyc();
    chk("stall_cnt_5", {60'd0, STALL_CNT}, 64'd5);
    for (int n = 0; n < 15; n++) cyc();
    chk("stall_cnt_sat", {60'd0, STALL_CNT}, 64'd15);
    chk_pay("stall_hold", pay_of(64'h42));
    drive(1'b1, 1'b0, 1'b0, '0);
    cyc();
    chk("flush_cnt_1", {60'd0, FLUSH_CNT}, 64'd1);
    chk("stall_cnt_keep", {60'd0, STALL_CNT}, 64'd15);
    cyc();
    chk("flush_cnt_empty", {60'd0, FLUSH_CNT}, 64'd1);
    drive(1'b0, 1'b0, 1'b0, '0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
